// File: rtl/char_plane_if.sv
// Stream-in / plane-write bundle between a text source, the writer and the character plane.
interface char_plane_if #(
    parameter int ROW_BIT_LEN    = 4,
    parameter int COL_BIT_LEN    = 6,
    parameter int CHAR_ID_LENGTH = 8
);
    logic [CHAR_ID_LENGTH-1:0] char_in;
    logic                      char_valid;
    logic                      char_ready;
    logic                      clear_req;
    logic                      busy;
    logic [ROW_BIT_LEN-1:0]    cursor_row;
    logic [COL_BIT_LEN-1:0]    cursor_col;
    logic [CHAR_ID_LENGTH-1:0] plane_data;
    logic [ROW_BIT_LEN-1:0]    plane_row;
    logic [COL_BIT_LEN-1:0]    plane_col;
    logic                      plane_we;

    modport master (
        output char_in, char_valid, clear_req,
        input  char_ready, busy, cursor_row, cursor_col,
        input  plane_data, plane_row, plane_col, plane_we
    );

    modport slave (
        input  char_in, char_valid, clear_req,
        output char_ready, busy, cursor_row, cursor_col,
        output plane_data, plane_row, plane_col, plane_we
    );
endinterface

// File: rtl/char_plane_writer.sv
// Cursor-driven writer for the character plane: one write per accepted char, blank sweeps for clears.
// Plane writes appear the cycle after acceptance; char_ready drops while sweeping or on clear_req.
module char_plane_writer #(
    parameter int                        ROW_NUMBER     = 15,
    parameter int                        COL_NUMBER     = 40,
    parameter int                        ROW_BIT_LEN    = 4,
    parameter int                        COL_BIT_LEN    = 6,
    parameter int                        CHAR_ID_LENGTH = 8,
    parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID       = '0
) (
    input  logic          clock,
    input  logic          reset,
    char_plane_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_ALL} state_t;

    localparam logic [ROW_BIT_LEN-1:0]    LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0]    LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_LF    = CHAR_ID_LENGTH'(8'h0A);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_FF    = CHAR_ID_LENGTH'(8'h0C);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_CR    = CHAR_ID_LENGTH'(8'h0D);

    state_t                    r_state, w_state_nxt;
    logic [ROW_BIT_LEN-1:0]    r_cur_row, w_cur_row_nxt;
    logic [COL_BIT_LEN-1:0]    r_cur_col, w_cur_col_nxt;
    logic [ROW_BIT_LEN-1:0]    r_sw_row, w_sw_row_nxt;
    logic [COL_BIT_LEN-1:0]    r_sw_col, w_sw_col_nxt;
    logic                      r_plane_we, w_plane_we_nxt;
    logic [CHAR_ID_LENGTH-1:0] r_plane_data, w_plane_data_nxt;
    logic [ROW_BIT_LEN-1:0]    r_plane_row, w_plane_row_nxt;
    logic [COL_BIT_LEN-1:0]    r_plane_col, w_plane_col_nxt;
    logic                      w_char_ready;
    logic                      w_xfer;

    assign w_char_ready = (r_state == ST_IDLE) && !bus.clear_req;
    assign w_xfer       = bus.char_valid && w_char_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_sw_row     <= '0;
            r_sw_col     <= '0;
            r_plane_we   <= 1'b0;
            r_plane_data <= '0;
            r_plane_row  <= '0;
            r_plane_col  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_row    <= w_cur_row_nxt;
            r_cur_col    <= w_cur_col_nxt;
            r_sw_row     <= w_sw_row_nxt;
            r_sw_col     <= w_sw_col_nxt;
            r_plane_we   <= w_plane_we_nxt;
            r_plane_data <= w_plane_data_nxt;
            r_plane_row  <= w_plane_row_nxt;
            r_plane_col  <= w_plane_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_row_nxt    = r_cur_row;
        w_cur_col_nxt    = r_cur_col;
        w_sw_row_nxt     = r_sw_row;
        w_sw_col_nxt     = r_sw_col;
        w_plane_we_nxt   = 1'b0;
        w_plane_data_nxt = r_plane_data;
        w_plane_row_nxt  = r_plane_row;
        w_plane_col_nxt  = r_plane_col;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear_req || (w_xfer && bus.char_in == CH_FF)) begin
                    w_state_nxt   = ST_CLR_ALL;
                    w_cur_row_nxt = '0;
                    w_cur_col_nxt = '0;
                    w_sw_row_nxt  = '0;
                    w_sw_col_nxt  = '0;
                end else if (w_xfer) begin
                    case (bus.char_in)
                        CH_CR: w_cur_col_nxt = '0;
                        CH_LF: begin
                            w_cur_col_nxt = '0;
                            if (r_cur_row == LAST_ROW) begin
                                w_cur_row_nxt = '0;
                                w_sw_row_nxt  = '0;
                                w_sw_col_nxt  = '0;
                                w_state_nxt   = ST_CLR_LINE;
                            end else begin
                                w_cur_row_nxt = r_cur_row + 1'b1;
                            end
                        end
                        CH_BS: begin
                            if (r_cur_col != '0) begin
                                w_cur_col_nxt    = r_cur_col - 1'b1;
                                w_plane_we_nxt   = 1'b1;
                                w_plane_data_nxt = BLANK_ID;
                                w_plane_row_nxt  = r_cur_row;
                                w_plane_col_nxt  = r_cur_col - 1'b1;
                            end else if (r_cur_row != '0) begin
                                w_cur_row_nxt    = r_cur_row - 1'b1;
                                w_cur_col_nxt    = LAST_COL;
                                w_plane_we_nxt   = 1'b1;
                                w_plane_data_nxt = BLANK_ID;
                                w_plane_row_nxt  = r_cur_row - 1'b1;
                                w_plane_col_nxt  = LAST_COL;
                            end
                        end
                        default: begin
                            w_plane_we_nxt   = 1'b1;
                            w_plane_data_nxt = bus.char_in;
                            w_plane_row_nxt  = r_cur_row;
                            w_plane_col_nxt  = r_cur_col;
                            if (r_cur_col != LAST_COL) begin
                                w_cur_col_nxt = r_cur_col + 1'b1;
                            end else begin
                                w_cur_col_nxt = '0;
                                // Running off the bottom recycles row 0 instead of scrolling.
                                if (r_cur_row == LAST_ROW) begin
                                    w_cur_row_nxt = '0;
                                    w_sw_row_nxt  = '0;
                                    w_sw_col_nxt  = '0;
                                    w_state_nxt   = ST_CLR_LINE;
                                end else begin
                                    w_cur_row_nxt = r_cur_row + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
                w_plane_we_nxt   = 1'b1;
                w_plane_data_nxt = BLANK_ID;
                w_plane_row_nxt  = r_sw_row;
                w_plane_col_nxt  = r_sw_col;
                if (r_sw_col != LAST_COL) begin
                    w_sw_col_nxt = r_sw_col + 1'b1;
                end else begin
                    w_sw_col_nxt = '0;
                    if (r_state == ST_CLR_LINE || r_sw_row == LAST_ROW) begin
                        w_sw_row_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_sw_row_nxt = r_sw_row + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.char_ready = w_char_ready;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.cursor_row = r_cur_row;
    assign bus.cursor_col = r_cur_col;
    assign bus.plane_we   = r_plane_we;
    assign bus.plane_data = r_plane_data;
    assign bus.plane_row  = r_plane_row;
    assign bus.plane_col  = r_plane_col;
endmodule

// File: tb/tb_char_plane_writer.sv
// Directed bench for char_plane_writer: typing, control codes, wrap clear, full clear, reset abort.
module tb_char_plane_writer;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    char_plane_if #(.ROW_BIT_LEN(4), .COL_BIT_LEN(6), .CHAR_ID_LENGTH(8)) bus ();

    char_plane_writer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_obs();
        return {13'b0, bus.plane_we, bus.plane_data, bus.plane_row, bus.plane_col};
    endfunction

    function automatic logic [31:0] wr_exp(input logic [3:0] r, input logic [5:0] c, input logic [7:0] d);
        return {13'b0, 1'b1, d, r, c};
    endfunction

    function automatic logic [31:0] cur_obs();
        return {22'b0, bus.cursor_row, bus.cursor_col};
    endfunction

    function automatic logic [31:0] cur_exp(input logic [3:0] r, input logic [5:0] c);
        return {22'b0, r, c};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [7:0] c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.char_valid = 1'b0;
    endtask

    initial begin
        int low_cycles;
        int busy_cycles;
        reset          = 1'b1;
        bus.char_in    = '0;
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_we", 32'(bus.plane_we), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cursor", cur_obs(), cur_exp(0, 0));
        check("rst_plane_bus", {14'b0, bus.plane_data, bus.plane_row, bus.plane_col}, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(bus.char_ready), 1);

        // Back-to-back printable chars
        @(negedge clock);
        bus.char_in    = 8'h41;
        bus.char_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("wr_A", wr_obs(), wr_exp(0, 0, 8'h41));
        check("cur_after_A", cur_obs(), cur_exp(0, 1));
        check("ready_after_A", 32'(bus.char_ready), 1);
        bus.char_in = 8'h42;
        @(posedge clock);
        @(negedge clock);
        check("wr_B", wr_obs(), wr_exp(0, 1, 8'h42));
        check("cur_after_B", cur_obs(), cur_exp(0, 2));
        check("ready_after_B", 32'(bus.char_ready), 1);
        bus.char_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("idle_no_we", 32'(bus.plane_we), 0);
        check("hold_plane_bus", {14'b0, bus.plane_data, bus.plane_row, bus.plane_col},
              {14'b0, 8'h42, 4'd0, 6'd1});

        // CR to column 0, then backspace at origin is a no-op
        send(8'h0D);
        check("cr_no_we", 32'(bus.plane_we), 0);
        check("cr_cursor", cur_obs(), cur_exp(0, 0));
        send(8'h08);
        check("bs_origin_no_we", 32'(bus.plane_we), 0);
        check("bs_origin_cursor", cur_obs(), cur_exp(0, 0));

        // Backspace from column 0 steps to the end of the previous row
        repeat (3) send(8'h0A);
        check("lf_x3_cursor", cur_obs(), cur_exp(3, 0));
        send(8'h08);
        check("bs_row_wr", wr_obs(), wr_exp(2, 39, 8'h00));
        check("bs_row_cursor", cur_obs(), cur_exp(2, 39));

        // CR / LF from (5,17)
        send(8'h0D);
        repeat (3) send(8'h0A);
        repeat (17) send(8'h30);
        check("pos_5_17", cur_obs(), cur_exp(5, 17));
        send(8'h0D);
        check("cr_5_no_we", 32'(bus.plane_we), 0);
        check("cr_5_cursor", cur_obs(), cur_exp(5, 0));
        send(8'h0A);
        check("lf_5_no_we", 32'(bus.plane_we), 0);
        check("lf_5_cursor", cur_obs(), cur_exp(6, 0));

        // Backspace within a row
        send(8'h58);
        send(8'h08);
        check("bs_col_wr", wr_obs(), wr_exp(6, 0, 8'h00));
        check("bs_col_cursor", cur_obs(), cur_exp(6, 0));

        // Print at the last cell: wrap to origin and clear row 0
        repeat (8) send(8'h0A);
        repeat (39) send(8'h31);
        check("pos_14_39", cur_obs(), cur_exp(14, 39));
        send(8'h55);
        check("wrap_wr", wr_obs(), wr_exp(14, 39, 8'h55));
        check("wrap_cursor", cur_obs(), cur_exp(0, 0));
        check("wrap_busy", 32'(bus.busy), 1);
        low_cycles = (bus.char_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("line_clr_%0d", i), wr_obs(), wr_exp(4'd0, 6'(i), 8'h00));
            if (bus.char_ready == 1'b0) low_cycles++;
        end
        check("line_clr_ready_low_cycles", 32'(low_cycles), 40);
        check("line_clr_done_ready", 32'(bus.char_ready), 1);
        check("line_clr_cursor", cur_obs(), cur_exp(0, 0));
        @(posedge clock);
        @(negedge clock);
        check("line_clr_after_we", 32'(bus.plane_we), 0);

        // clear_req beats a valid char in the same cycle
        send(8'h51);
        bus.clear_req  = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h41;
        #1;
        check("clr_req_ready", 32'(bus.char_ready), 0);
        @(posedge clock);
        @(negedge clock);
        bus.clear_req = 1'b0;
        check("clr_all_busy", 32'(bus.busy), 1);
        check("clr_all_first_no_we", 32'(bus.plane_we), 0);
        check("clr_all_cursor", cur_obs(), cur_exp(0, 0));
        busy_cycles = 1;
        for (int k = 0; k < 600; k++) begin
            if (k == 100) bus.clear_req = 1'b1;
            if (k == 101) bus.clear_req = 1'b0;
            @(posedge clock);
            @(negedge clock);
            check($sformatf("clr_all_%0d", k), wr_obs(), wr_exp(4'(k / 40), 6'(k % 40), 8'h00));
            if (bus.busy) busy_cycles++;
        end
        check("clr_all_busy_cycles", 32'(busy_cycles), 600);
        check("clr_all_done_ready", 32'(bus.char_ready), 1);
        @(posedge clock);
        @(negedge clock);
        bus.char_valid = 1'b0;
        check("clr_all_held_char_wr", wr_obs(), wr_exp(0, 0, 8'h41));
        check("clr_all_held_char_cursor", cur_obs(), cur_exp(0, 1));

        // 0x0C starts a full clear; reset at cell 250 aborts it
        send(8'h0C);
        check("ff_busy", 32'(bus.busy), 1);
        check("ff_cursor", cur_obs(), cur_exp(0, 0));
        repeat (251) @(posedge clock);
        @(negedge clock);
        check("ff_cell_250", wr_obs(), wr_exp(6, 10, 8'h00));
        reset = 1'b1;
        #1;
        check("abort_we", 32'(bus.plane_we), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_cursor", cur_obs(), cur_exp(0, 0));
        @(posedge clock);
        @(negedge clock);
        check("abort_hold_we", 32'(bus.plane_we), 0);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(bus.char_ready), 1);
        @(negedge clock);
        send(8'h61);
        check("abort_next_wr", wr_obs(), wr_exp(0, 0, 8'h61));
        check("abort_next_cursor", cur_obs(), cur_exp(0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
